alu_uart_interface: RTL and testbench
=====================================

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
- REQ-001: Parameter DATA_WIDTH, default 8, width of operands, ALU result and received/transmitted bytes.
- REQ-002: Parameter OP_WIDTH, default 6, width of the ALU opcode, taken from the low bits of the opcode byte.
- REQ-003: Parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity over data plus parity bit.
- REQ-004: Port i_clock, input, 1, system clock; port i_reset, input, 1, reset: synchronous, active-high.
- REQ-005: i_rx_done, input, 1, frame-complete flag from the UART receiver, high one or more cycles per frame.
- REQ-006: i_rx_data, input, DATA_WIDTH, received byte, valid while i_rx_done is high.
- REQ-007: i_rx_parity, input, 1, received parity bit, valid while i_rx_done is high.
- REQ-008: i_alu_result, input, DATA_WIDTH, combinational ALU result for current o_alu_a/o_alu_b/o_alu_op.
- REQ-009: i_tx_done, input, 1, transmitter finished pulse.
- REQ-010: o_alu_a, output, DATA_WIDTH, operand A; o_alu_b, output, DATA_WIDTH, operand B; o_alu_op, output, OP_WIDTH, opcode.
- REQ-011: o_tx_start, output, 1, one-cycle transmit request; o_tx_data, output, DATA_WIDTH, byte to transmit.
- REQ-012: o_parity_err, output, 1, one-cycle pulse on a discarded bad-parity byte; o_overrun, output, 1, one-cycle pulse on a byte dropped while busy.

Function
- REQ-013: The block SHALL register i_rx_done and act only on its rising edge (current high, previous low), so a multi-cycle done counts once.
- REQ-014: Parity check SHALL be XOR of i_rx_data and i_rx_parity; a byte is good when the XOR equals PARITY_ODD.
- REQ-015: FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
- REQ-016: In WAIT_A, WAIT_B and WAIT_OP, a good byte SHALL update o_alu_a, o_alu_b or o_alu_op (low OP_WIDTH bits) respectively on the edge cycle, and the FSM SHALL advance to the next state.
- REQ-017: A bad-parity byte in a WAIT state SHALL leave all operands unchanged, pulse o_parity_err for the next cycle, and keep the FSM in the same state.
- REQ-018: COMPUTE SHALL last exactly one cycle, latch i_alu_result into o_tx_data, and go to SEND.
- REQ-019: SEND SHALL assert o_tx_start for exactly one cycle and go to WAIT_TX.
- REQ-020: WAIT_TX SHALL return to WAIT_A on i_tx_done high, with no timeout.
- REQ-021: A done edge in COMPUTE, SEND or WAIT_TX SHALL be dropped, pulse o_overrun for the next cycle, and not change the FSM.
- REQ-022: Operands and o_tx_data SHALL hold their values until overwritten by a later capture.
- REQ-023: Latency from the opcode done edge to o_tx_start high SHALL be 2 cycles (capture, COMPUTE, then SEND asserted).
- REQ-024: i_tx_done outside WAIT_TX SHALL be ignored.

Reset
- REQ-025: On i_reset the FSM SHALL enter WAIT_A, and all outputs and the done-edge register SHALL be 0.
- REQ-026: i_reset SHALL take priority over all events, including mid-transaction, and any captured operands SHALL be lost.

Structure
- REQ-027: State encodings and the default DATA_WIDTH and OP_WIDTH SHALL live in a shared UART/ALU package.
- REQ-028: The done-edge detector plus parity checker SHALL be one sub-module, rx_byte_checker, outputting byte_valid and parity_err pulses.

Verification
- REQ-029: With PARITY_ODD=0, send A=0x05 (parity 0), B=0x03 (parity 0), OP=0x20 (parity 1) with a reference ALU model -> o_tx_start 2 cycles after the OP edge, and o_tx_data=0x08.
- REQ-030: Send A=0x07 with parity 0 -> o_parity_err pulse, o_alu_a stays 0x00, FSM in WAIT_A; resend with parity 1 -> o_alu_a=0x07.
- REQ-031: Hold i_rx_done high for 3 cycles with B=0x10 -> exactly one capture, and FSM advances exactly one state.
- REQ-032: Done edge in WAIT_TX -> o_overrun pulse, and operands unchanged; then i_tx_done -> FSM in WAIT_A.
- REQ-033: i_reset asserted in WAIT_OP after A=0xAA and B=0x55 -> all outputs 0 next cycle, and FSM in WAIT_A.
- REQ-034: Back-to-back transactions, A=0xFF, B=0x01, OP=0x20, then A=0x80, B=0x80, OP=0x20 -> two o_tx_start pulses, with o_tx_data 0x00 then 0x00 (wrap-around).

Source files
------------

// File: rtl/alu_uart_interface_pkg.sv
// Shared types and defaults for the UART-fed ALU sequencer.
package alu_uart_interface_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OP_WIDTH   = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  // States in which an incoming byte cannot be accepted.
  function automatic logic is_busy(state_e s);
    return (s == COMPUTE) || (s == SEND) || (s == WAIT_TX);
  endfunction

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundles the receiver, ALU and transmitter connections of the sequencer.
interface alu_uart_interface_if
  import alu_uart_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH
) ();

  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_parity;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic                  o_tx_start;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_parity_err;
  logic                  o_overrun;

  // Sequencer side.
  modport slave (
    input  i_rx_done, i_rx_data, i_rx_parity, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
           o_parity_err, o_overrun
  );

  // Surrounding UART/ALU side.
  modport master (
    output i_rx_done, i_rx_data, i_rx_parity, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
           o_parity_err, o_overrun
  );

endinterface

// File: rtl/alu_uart_interface_rx_byte_checker.sv
// Turns the receiver's done level into a single-cycle event and splits it
// into good-byte and bad-parity pulses on the same cycle as the rising edge.
module rx_byte_checker
  import alu_uart_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_parity,
  output logic                  byte_valid,
  output logic                  parity_err
);

  logic rx_done_q, rx_done_d;
  logic done_edge;
  logic parity_ok;

  // Edge detect and parity classification of the incoming byte.
  always_comb begin
    rx_done_d  = i_rx_done;
    done_edge  = i_rx_done & ~rx_done_q;
    parity_ok  = ((^i_rx_data) ^ i_rx_parity) == PARITY_ODD;
    byte_valid = done_edge & parity_ok;
    parity_err = done_edge & ~parity_ok;
  end

  // Previous-cycle copy of the done flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) rx_done_q <= 1'b0;
    else         rx_done_q <= rx_done_d;
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and an opcode from UART bytes, samples the
// external ALU result and hands it to the transmitter.
//
//   state   | meaning
//   --------+------------------------------------------------
//   WAIT_A  | waiting for operand A byte
//   WAIT_B  | waiting for operand B byte
//   WAIT_OP | waiting for opcode byte
//   COMPUTE | one cycle: latch ALU result into tx data
//   SEND    | tx_start is high during this cycle
//   WAIT_TX | waiting for transmitter done
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                i_clock,
  input logic                i_reset,
  alu_uart_interface_if.slave bus
);

  logic byte_valid;
  logic parity_err;

  rx_byte_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARITY_ODD (PARITY_ODD)
  ) u_rx_byte_checker (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx_done   (bus.i_rx_done),
    .i_rx_data   (bus.i_rx_data),
    .i_rx_parity (bus.i_rx_parity),
    .byte_valid  (byte_valid),
    .parity_err  (parity_err)
  );

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  parity_err_q, parity_err_d;
  logic                  overrun_q, overrun_d;

  // Next-state and next-output logic; pulses are raised one cycle early so
  // the registered copies line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      WAIT_A: begin
        if (byte_valid) begin
          alu_a_d = bus.i_rx_data;
          state_d = WAIT_B;
        end else if (parity_err) begin
          parity_err_d = 1'b1;
        end
      end
      WAIT_B: begin
        if (byte_valid) begin
          alu_b_d = bus.i_rx_data;
          state_d = WAIT_OP;
        end else if (parity_err) begin
          parity_err_d = 1'b1;
        end
      end
      WAIT_OP: begin
        if (byte_valid) begin
          alu_op_d = bus.i_rx_data[OP_WIDTH-1:0];
          state_d  = COMPUTE;
        end else if (parity_err) begin
          parity_err_d = 1'b1;
        end
      end
      COMPUTE: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done) state_d = WAIT_A;
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase

    // Any byte arriving while a result is in flight is dropped, good or bad.
    if (is_busy(state_q) && (byte_valid || parity_err)) overrun_d = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= WAIT_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.o_alu_a      = alu_a_q;
  assign bus.o_alu_b      = alu_b_q;
  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_parity_err = parity_err_q;
  assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed table, hand sequences, and a
// randomized run against a transaction-level reference model.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int OW = DEF_OP_WIDTH;
  localparam bit PO = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_uart_interface_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_uart_interface #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .PARITY_ODD(PO)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Reference ALU, MIPS-style function codes.
  function automatic logic [DW-1:0] ref_alu(logic [DW-1:0] a, logic [DW-1:0] b,
                                            logic [OW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return DW'($signed(a) >>> b[2:0]);
      default: return '0;
    endcase
  endfunction

  assign bus.i_alu_result = ref_alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  function automatic logic good_par(logic [DW-1:0] d);
    return (^d) ^ PO;
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  // Presents a byte with done held for 'hold' cycles, then one idle cycle.
  // Counts pulses seen and remembers tx data on a start pulse.
  task automatic send_byte(input logic [DW-1:0] d, input logic p, input int hold,
                           output int perr_n, output int ovr_n, output int start_n,
                           output logic [DW-1:0] txd);
    perr_n = 0; ovr_n = 0; start_n = 0; txd = '0;
    bus.i_rx_data   = d;
    bus.i_rx_parity = p;
    bus.i_rx_done   = 1'b1;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) bus.i_rx_done = 1'b0;
      tick();
      perr_n  += int'(bus.o_parity_err);
      ovr_n   += int'(bus.o_overrun);
      if (bus.o_tx_start) begin
        start_n++;
        txd = bus.o_tx_data;
      end
    end
  endtask

  task automatic check_ops(input string tag, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OW-1:0] op);
    check({tag, "_a"},  32'(bus.o_alu_a),  32'(a));
    check({tag, "_b"},  32'(bus.o_alu_b),  32'(b));
    check({tag, "_op"}, 32'(bus.o_alu_op), 32'(op));
  endtask

  task automatic check_all_zero(input string tag);
    check_ops(tag, '0, '0, '0);
    check({tag, "_txd"},   32'(bus.o_tx_data),    32'd0);
    check({tag, "_start"}, 32'(bus.o_tx_start),   32'd0);
    check({tag, "_perr"},  32'(bus.o_parity_err), 32'd0);
    check({tag, "_ovr"},   32'(bus.o_overrun),    32'd0);
  endtask

  // Transaction-level model: bytes are gathered three at a time; once the
  // third lands at cycle c0 the result goes out at c0+2 and the block is
  // deaf until a tx_done seen at c0+3 or later.
  int            m_cnt, m_c0, m_cyc;
  logic          m_prev, m_busy;
  logic [DW-1:0] m_a, m_b, m_txd;
  logic [OW-1:0] m_op;
  logic          e_perr, e_ovr, e_start;

  task automatic model_reset();
    m_cnt = 0; m_c0 = 0; m_prev = 1'b0; m_busy = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_txd = '0;
    e_perr = 1'b0; e_ovr = 1'b0; e_start = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic done, input logic [DW-1:0] d,
                            input logic p, input logic txdone);
    logic edge_seen;
    if (r) begin
      model_reset();
      m_cyc++;
      return;
    end
    edge_seen = done && !m_prev;
    m_prev = done;
    e_perr = 1'b0; e_ovr = 1'b0; e_start = 1'b0;
    if (!m_busy) begin
      if (edge_seen) begin
        if (((^d) ^ p) == PO) begin
          if (m_cnt == 0)      m_a  = d;
          else if (m_cnt == 1) m_b  = d;
          else                 m_op = d[OW-1:0];
          m_cnt++;
          if (m_cnt == 3) begin
            m_cnt  = 0;
            m_busy = 1'b1;
            m_c0   = m_cyc;
          end
        end else begin
          e_perr = 1'b1;
        end
      end
    end else begin
      if (edge_seen) e_ovr = 1'b1;
      if (m_cyc == m_c0 + 1) begin
        m_txd   = ref_alu(m_a, m_b, m_op);
        e_start = 1'b1;
      end
      if (m_cyc >= m_c0 + 3 && txdone) m_busy = 1'b0;
    end
    m_cyc++;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    int            hold;
    int            exp_perr;
    int            exp_ovr;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [OW-1:0] exp_op;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int            pe, ov, st;
    logic [DW-1:0] txd;
    logic          r_rst;

    vecs[0] = '{8'h07, 1'b0, 1, 1, 0, 8'h00, 8'h00, 6'h00};
    vecs[1] = '{8'h07, 1'b1, 1, 0, 0, 8'h07, 8'h00, 6'h00};
    vecs[2] = '{8'h10, 1'b1, 3, 0, 0, 8'h07, 8'h10, 6'h00};
    vecs[3] = '{8'h3F, 1'b0, 1, 0, 0, 8'h07, 8'h10, 6'h3F};
    vecs[4] = '{8'h55, 1'b0, 2, 0, 1, 8'h07, 8'h10, 6'h3F};
    vecs[5] = '{8'hC3, 1'b1, 1, 0, 1, 8'h07, 8'h10, 6'h3F};

    bus.i_rx_done = 1'b0; bus.i_rx_data = '0; bus.i_rx_parity = 1'b0; bus.i_tx_done = 1'b0;
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // Basic transaction with explicit latency from the opcode edge.
    send_byte(8'h05, 1'b0, 1, pe, ov, st, txd);
    send_byte(8'h03, 1'b0, 1, pe, ov, st, txd);
    check_ops("ab_capt", 8'h05, 8'h03, 6'h00);
    bus.i_rx_data = 8'h20; bus.i_rx_parity = 1'b1; bus.i_rx_done = 1'b1;
    tick();
    check("lat_cyc1_start", 32'(bus.o_tx_start), 32'd0);
    bus.i_rx_done = 1'b0;
    tick();
    check("lat_cyc2_start", 32'(bus.o_tx_start), 32'd1);
    check("lat_cyc2_txd",   32'(bus.o_tx_data),  32'h08);
    tick();
    check("start_one_cyc",  32'(bus.o_tx_start), 32'd0);
    check("txd_hold",       32'(bus.o_tx_data),  32'h08);

    // Byte in WAIT_TX is dropped; tx_done returns to WAIT_A.
    send_byte(8'h11, 1'b0, 1, pe, ov, st, txd);
    check("waittx_ovr",  32'(ov), 32'd1);
    check("waittx_perr", 32'(pe), 32'd0);
    check_ops("waittx_ops", 8'h05, 8'h03, 6'h20);
    pulse_tx_done();
    send_byte(8'h42, 1'b0, 1, pe, ov, st, txd);
    check("after_txdone_a", 32'(bus.o_alu_a), 32'h42);

    // Table: parity rejection, held done, one-state advance, busy drops.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].data, vecs[i].par, vecs[i].hold, pe, ov, st, txd);
      check($sformatf("vec%0d_perr", i), 32'(pe), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_ovr", i),  32'(ov), 32'(vecs[i].exp_ovr));
      check_ops($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op);
    end
    pulse_tx_done();

    // tx_done while collecting is ignored.
    do_reset();
    send_byte(8'h01, 1'b1, 1, pe, ov, st, txd);
    pulse_tx_done();
    send_byte(8'h02, 1'b1, 1, pe, ov, st, txd);
    check_ops("txdone_ignored", 8'h01, 8'h02, 6'h00);

    // Reset in WAIT_OP discards operands.
    do_reset();
    send_byte(8'hAA, 1'b0, 1, pe, ov, st, txd);
    send_byte(8'h55, 1'b0, 1, pe, ov, st, txd);
    check_ops("pre_rst", 8'hAA, 8'h55, 6'h00);
    rst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    rst = 1'b0;
    send_byte(8'h01, 1'b1, 1, pe, ov, st, txd);
    check_ops("post_rst", 8'h01, 8'h00, 6'h00);

    // Back-to-back wrap-around transactions.
    do_reset();
    send_byte(8'hFF, 1'b0, 1, pe, ov, st, txd);
    send_byte(8'h01, 1'b1, 1, pe, ov, st, txd);
    send_byte(8'h20, 1'b1, 1, pe, ov, st, txd);
    check("b2b1_starts", 32'(st), 32'd1);
    check("b2b1_txd",    32'(txd), 32'h00);
    tick();
    pulse_tx_done();
    send_byte(8'h80, 1'b1, 1, pe, ov, st, txd);
    send_byte(8'h80, 1'b1, 1, pe, ov, st, txd);
    send_byte(8'h20, 1'b1, 1, pe, ov, st, txd);
    check("b2b2_starts", 32'(st), 32'd1);
    check("b2b2_txd",    32'(txd), 32'h00);
    tick();
    pulse_tx_done();

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    m_cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_a",     32'(bus.o_alu_a),      32'(m_a));
      check("rnd_b",     32'(bus.o_alu_b),      32'(m_b));
      check("rnd_op",    32'(bus.o_alu_op),     32'(m_op));
      check("rnd_txd",   32'(bus.o_tx_data),    32'(m_txd));
      check("rnd_start", 32'(bus.o_tx_start),   32'(e_start));
      check("rnd_perr",  32'(bus.o_parity_err), 32'(e_perr));
      check("rnd_ovr",   32'(bus.o_overrun),    32'(e_ovr));
      r_rst = ($urandom_range(0, 299) == 0);
      rst = r_rst;
      if ($urandom_range(0, 2) == 0) bus.i_rx_done = ~bus.i_rx_done;
      bus.i_rx_data   = DW'($urandom);
      bus.i_rx_parity = good_par(bus.i_rx_data) ^ ($urandom_range(0, 4) == 0);
      bus.i_tx_done   = ($urandom_range(0, 5) == 0);
      model_step(r_rst, bus.i_rx_done, bus.i_rx_data, bus.i_rx_parity, bus.i_tx_done);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
